pipeline_hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage RV32 pipeline; sits beside the operand-forwarding logic.
- Handles cases forwarding cannot: load-use hazards, taken-branch flushes, multi-cycle mul/div in EXE, and IM/DM wait states.
- Drives per-stage register write-enables and flushes, plus two saturating performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/sat_counter.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states, the x0 register
// index, and the per-stage register control bundle.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } state_t;

   localparam logic [4:0] X0 = 5'd0;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic id_exe_write;
      logic exe_mem_write;
      logic mem_wb_write;
      logic if_id_flush;
      logic id_exe_flush;
      logic exe_mem_bubble;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTRL_IDLE      = stage_ctrl_t'(8'b00000_000);
   localparam stage_ctrl_t CTRL_ALL_WRITE = stage_ctrl_t'(8'b11111_000);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles where inc is high and sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + ONE;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32 pipeline: load-use bubbles,
// taken-branch flushes, multi-cycle mul/div holds and memory wait-state freezes.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             exe_mem_read,
   input  logic [4:0]       exe_rd_addr,
   input  logic             exe_branch_taken,
   input  logic             exe_md_op,
   input  logic             md_done,
   input  logic             im_stall,
   input  logic             dm_stall,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_exe_write,
   output logic             exe_mem_write,
   output logic             mem_wb_write,
   output logic             if_id_flush,
   output logic             id_exe_flush,
   output logic             exe_mem_bubble,
   output logic             md_start,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_t      state;
   state_t      state_next;
   logic        done_seen;
   logic        done_seen_next;
   stage_ctrl_t ctrl;
   logic        md_start_c;
   logic        flush_inc;
   logic        freeze;
   logic        load_use;

   assign freeze   = im_stall | dm_stall;
   assign load_use = exe_mem_read && (exe_rd_addr != X0) &&
                     ((id_rs1_used && (id_rs1_addr == exe_rd_addr)) ||
                      (id_rs2_used && (id_rs2_addr == exe_rd_addr)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         done_seen <= 1'b0;
      end else begin
         state     <= state_next;
         done_seen <= done_seen_next;
      end
   end

   // A freeze holds everything; a mul/div completion seen during it is remembered
   // so MD_BUSY can retire as soon as the memories are ready again.
   always_comb begin
      ctrl           = CTRL_IDLE;
      md_start_c     = 1'b0;
      flush_inc      = 1'b0;
      state_next     = state;
      done_seen_next = done_seen;
      if (freeze) begin
         if ((state == MD_BUSY) && md_done)
            done_seen_next = 1'b1;
      end else if (state == RUN) begin
         if (exe_branch_taken) begin
            ctrl              = CTRL_ALL_WRITE;
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_exe_flush = 1'b1;
            flush_inc         = 1'b1;
         end else if (exe_md_op) begin
            ctrl.exe_mem_write  = 1'b1;
            ctrl.exe_mem_bubble = 1'b1;
            ctrl.mem_wb_write   = 1'b1;
            md_start_c          = 1'b1;
            state_next          = MD_BUSY;
         end else if (load_use) begin
            ctrl.id_exe_write  = 1'b1;
            ctrl.id_exe_flush  = 1'b1;
            ctrl.exe_mem_write = 1'b1;
            ctrl.mem_wb_write  = 1'b1;
         end else begin
            ctrl = CTRL_ALL_WRITE;
         end
      end else begin
         if (md_done || done_seen) begin
            ctrl           = CTRL_ALL_WRITE;
            done_seen_next = 1'b0;
            state_next     = RUN;
         end else begin
            ctrl.exe_mem_write  = 1'b1;
            ctrl.exe_mem_bubble = 1'b1;
            ctrl.mem_wb_write   = 1'b1;
         end
      end
   end

   // Outputs are forced low for the whole time reset is held, regardless of inputs.
   assign pc_write       = ctrl.pc_write       & ~rst;
   assign if_id_write    = ctrl.if_id_write    & ~rst;
   assign id_exe_write   = ctrl.id_exe_write   & ~rst;
   assign exe_mem_write  = ctrl.exe_mem_write  & ~rst;
   assign mem_wb_write   = ctrl.mem_wb_write   & ~rst;
   assign if_id_flush    = ctrl.if_id_flush    & ~rst;
   assign id_exe_flush   = ctrl.id_exe_flush   & ~rst;
   assign exe_mem_bubble = ctrl.exe_mem_bubble & ~rst;
   assign md_start       = md_start_c          & ~rst;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (~ctrl.pc_write),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

endmodule
